// File: rtl/seq_detector_param_if.sv
// Serial-stream bus of the pattern detector: stream, pattern load and counter
// control in, match flags, match count and debug state out.
interface seq_detector_param_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic             en;
    logic             din;
    logic             pat_load;
    logic [N-1:0]     pat_in;
    logic             cnt_clr;
    logic             dout;
    logic             dout_q;
    logic [CNT_W-1:0] match_cnt;
    logic [SW-1:0]    state_o;

    modport master (
        output en, din, pat_load, pat_in, cnt_clr,
        input  dout, dout_q, match_cnt, state_o
    );

    modport slave (
        input  en, din, pat_load, pat_in, cnt_clr,
        output dout, dout_q, match_cnt, state_o
    );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-pattern detector with KMP fallback, optional
// overlapping matches, loadable pattern and a saturating match counter.
module seq_detector_param #(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b1010,
    parameter int           OVERLAP = 0,
    parameter int           CNT_W   = 8
) (
    input logic                clk,
    input logic                reset,
    seq_detector_param_if.slave bus
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    typedef logic [SW-1:0] state_t;
    localparam state_t           LAST    = state_t'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_reg, state_next;
    logic [N-1:0]     pat_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             dout_q_reg;
    logic             dout_c;
    logic             exp_bit;
    logic             hit;
    state_t           border_len, fallback_len;

    // Bit i of the pattern in arrival order (i=0 is the first bit received).
    function automatic logic pbit(input logic [N-1:0] p, input int i);
        logic [N-1:0] sh;
        sh = p >> (N - 1 - i);
        return sh[0];
    endfunction

    assign exp_bit = pbit(pat_reg, int'(state_reg));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= '0;
            pat_reg    <= PATTERN;
            cnt_reg    <= '0;
            dout_q_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            dout_q_reg <= dout_c;
            if (bus.pat_load)
                pat_reg <= bus.pat_in;
            if (bus.cnt_clr)
                cnt_reg <= '0;
            else if (dout_c && (cnt_reg != CNT_MAX))
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_comb begin
        border_len   = '0;
        fallback_len = '0;
        hit          = 1'b0;
        state_next   = state_reg;

        // Border: longest proper suffix of the pattern that is also a prefix.
        for (int j = 1; j < N; j++) begin
            hit = 1'b1;
            for (int m = 0; m < j; m++)
                if (pbit(pat_reg, N - j + m) != pbit(pat_reg, m))
                    hit = 1'b0;
            if (hit)
                border_len = state_t'(j);
        end

        // Fallback: longest prefix that ends the matched k bits followed by din.
        for (int j = 1; j < N; j++) begin
            if (j <= int'(state_reg)) begin
                hit = (bus.din == pbit(pat_reg, j - 1));
                for (int m = 0; m < j - 1; m++)
                    if (pbit(pat_reg, int'(state_reg) + 1 - j + m) != pbit(pat_reg, m))
                        hit = 1'b0;
                if (hit)
                    fallback_len = state_t'(j);
            end
        end

        if (bus.pat_load) begin
            state_next = '0;
        end else if (bus.en) begin
            if (bus.din == exp_bit) begin
                if (state_reg == LAST)
                    state_next = (OVERLAP != 0) ? border_len : '0;
                else
                    state_next = state_reg + state_t'(1);
            end else begin
                state_next = fallback_len;
            end
        end
    end

    always_comb begin
        dout_c = 1'b0;
        if (reset && !bus.pat_load && bus.en && (bus.din == exp_bit) && (state_reg == LAST))
            dout_c = 1'b1;
    end

    assign bus.dout      = dout_c;
    assign bus.dout_q    = dout_q_reg;
    assign bus.match_cnt = cnt_reg;
    assign bus.state_o   = state_reg;
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: three instances cover non-overlapping,
// overlapping and narrow-counter configurations on a shared clock and reset.
module tb_seq_detector_param;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    seq_detector_param_if #(.N(4), .CNT_W(8)) if_def ();
    seq_detector_param_if #(.N(4), .CNT_W(8)) if_ovl ();
    seq_detector_param_if #(.N(4), .CNT_W(2)) if_sat ();

    seq_detector_param #(.N(4), .PATTERN(4'b1010), .OVERLAP(0), .CNT_W(8)) u_def (
        .clk(clk), .reset(reset), .bus(if_def)
    );
    seq_detector_param #(.N(4), .PATTERN(4'b1010), .OVERLAP(1), .CNT_W(8)) u_ovl (
        .clk(clk), .reset(reset), .bus(if_ovl)
    );
    seq_detector_param #(.N(4), .PATTERN(4'b1010), .OVERLAP(0), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .bus(if_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_dout(input int sel);
        case (sel)
            0:       return {31'd0, if_def.dout};
            1:       return {31'd0, if_ovl.dout};
            default: return {31'd0, if_sat.dout};
        endcase
    endfunction

    function automatic logic [31:0] get_dout_q(input int sel);
        case (sel)
            0:       return {31'd0, if_def.dout_q};
            1:       return {31'd0, if_ovl.dout_q};
            default: return {31'd0, if_sat.dout_q};
        endcase
    endfunction

    function automatic logic [31:0] get_state(input int sel);
        case (sel)
            0:       return {30'd0, if_def.state_o};
            1:       return {30'd0, if_ovl.state_o};
            default: return {30'd0, if_sat.state_o};
        endcase
    endfunction

    function automatic logic [31:0] get_cnt(input int sel);
        case (sel)
            0:       return {24'd0, if_def.match_cnt};
            1:       return {24'd0, if_ovl.match_cnt};
            default: return {30'd0, if_sat.match_cnt};
        endcase
    endfunction

    task automatic idle_all();
        if_def.en = 1'b0; if_def.din = 1'b0; if_def.pat_load = 1'b0; if_def.cnt_clr = 1'b0;
        if_ovl.en = 1'b0; if_ovl.din = 1'b0; if_ovl.pat_load = 1'b0; if_ovl.cnt_clr = 1'b0;
        if_sat.en = 1'b0; if_sat.din = 1'b0; if_sat.pat_load = 1'b0; if_sat.cnt_clr = 1'b0;
    endtask

    // One clock of stimulus on instance sel; dout checked mid-cycle, registers after the edge.
    task automatic step(input int sel, input logic e, input logic d, input logic pl,
                        input logic [3:0] pin, input logic clr, input logic exp_dout,
                        input int exp_state, input int exp_cnt, input string tag);
        logic [31:0] obs_dout;
        idle_all();
        case (sel)
            0: begin if_def.en = e; if_def.din = d; if_def.pat_load = pl; if_def.pat_in = pin; if_def.cnt_clr = clr; end
            1: begin if_ovl.en = e; if_ovl.din = d; if_ovl.pat_load = pl; if_ovl.pat_in = pin; if_ovl.cnt_clr = clr; end
            default: begin if_sat.en = e; if_sat.din = d; if_sat.pat_load = pl; if_sat.pat_in = pin; if_sat.cnt_clr = clr; end
        endcase
        @(negedge clk);
        obs_dout = get_dout(sel);
        chk({tag, ".dout"}, obs_dout, {31'd0, exp_dout});
        @(posedge clk);
        #1;
        chk({tag, ".state"},  get_state(sel),  exp_state);
        chk({tag, ".dout_q"}, get_dout_q(sel), {31'd0, exp_dout});
        chk({tag, ".cnt"},    get_cnt(sel),    exp_cnt);
        $display("%s: dut=%0d en=%0b din=%0b load=%0b clr=%0b dout=%0d state=%0d cnt=%0d",
                 tag, sel, e, d, pl, clr, obs_dout, get_state(sel), get_cnt(sel));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_all();
        if_def.pat_in = 4'b0000; if_ovl.pat_in = 4'b0000; if_sat.pat_in = 4'b0000;
        reset = 1'b0;
        if_def.en = 1'b1; if_def.din = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.dout",   get_dout(0),   0);
        chk("rst.def.st", get_state(0),  0);
        chk("rst.def.cnt", get_cnt(0),   0);
        chk("rst.def.dq", get_dout_q(0), 0);
        chk("rst.ovl.st", get_state(1),  0);
        chk("rst.sat.cnt", get_cnt(2),   0);
        reset = 1'b1;
        idle_all();

        // Non-overlapping 1010 over 10101010: matches on bits 4 and 8.
        step(0, 1, 1, 0, 4'h0, 0, 0, 1, 0, "def.b1");
        step(0, 1, 0, 0, 4'h0, 0, 0, 2, 0, "def.b2");
        step(0, 1, 1, 0, 4'h0, 0, 0, 3, 0, "def.b3");
        step(0, 1, 0, 0, 4'h0, 0, 1, 0, 1, "def.b4");
        step(0, 1, 1, 0, 4'h0, 0, 0, 1, 1, "def.b5");
        step(0, 1, 0, 0, 4'h0, 0, 0, 2, 1, "def.b6");
        step(0, 1, 1, 0, 4'h0, 0, 0, 3, 1, "def.b7");
        step(0, 1, 0, 0, 4'h0, 0, 1, 0, 2, "def.b8");

        // Overlapping: border of 1010 is 2, matches on bits 4, 6 and 8.
        step(1, 1, 1, 0, 4'h0, 0, 0, 1, 0, "ovl.b1");
        step(1, 1, 0, 0, 4'h0, 0, 0, 2, 0, "ovl.b2");
        step(1, 1, 1, 0, 4'h0, 0, 0, 3, 0, "ovl.b3");
        step(1, 1, 0, 0, 4'h0, 0, 1, 2, 1, "ovl.b4");
        step(1, 1, 1, 0, 4'h0, 0, 0, 3, 1, "ovl.b5");
        step(1, 1, 0, 0, 4'h0, 0, 1, 2, 2, "ovl.b6");
        step(1, 1, 1, 0, 4'h0, 0, 0, 3, 2, "ovl.b7");
        step(1, 1, 0, 0, 4'h0, 0, 1, 2, 3, "ovl.b8");

        // Load 1011 (din discarded), then 101011: KMP fallback 3->2 on bit 4.
        step(0, 1, 1, 1, 4'b1011, 0, 0, 0, 2, "ld.load");
        step(0, 1, 1, 0, 4'h0, 0, 0, 1, 2, "ld.b1");
        step(0, 1, 0, 0, 4'h0, 0, 0, 2, 2, "ld.b2");
        step(0, 1, 1, 0, 4'h0, 0, 0, 3, 2, "ld.b3");
        step(0, 1, 0, 0, 4'h0, 0, 0, 2, 2, "ld.b4");
        step(0, 1, 1, 0, 4'h0, 0, 0, 3, 2, "ld.b5");
        step(0, 1, 1, 0, 4'h0, 0, 1, 0, 3, "ld.b6");

        // en gaps: state held at 2 across three idle cycles with random din.
        step(1, 1, 1, 1, 4'b1010, 0, 0, 0, 3, "gap.load");
        step(1, 1, 1, 0, 4'h0, 0, 0, 1, 3, "gap.b1");
        step(1, 1, 0, 0, 4'h0, 0, 0, 2, 3, "gap.b2");
        for (int i = 0; i < 3; i++)
            step(1, 0, 1'($urandom_range(0, 1)), 0, 4'h0, 0, 0, 2, 3, "gap.idle");
        step(1, 1, 1, 0, 4'h0, 0, 0, 3, 3, "gap.b3");
        step(1, 1, 0, 0, 4'h0, 0, 1, 2, 4, "gap.b4");

        // Two-bit counter: twelve back-to-back matches saturate at 3.
        for (int i = 0; i < 48; i++) begin
            int m;
            m = (i / 4) + ((i % 4 == 3) ? 1 : 0);
            step(2, 1, (i % 2 == 0), 0, 4'h0, 0, (i % 4 == 3), (i + 1) % 4,
                 (m > 3) ? 3 : m, "sat");
        end
        // Clear coincident with a match wins; dout still fires.
        step(2, 1, 1, 0, 4'h0, 0, 0, 1, 3, "clr.b1");
        step(2, 1, 0, 0, 4'h0, 0, 0, 2, 3, "clr.b2");
        step(2, 1, 1, 0, 4'h0, 0, 0, 3, 3, "clr.b3");
        step(2, 1, 0, 0, 4'h0, 1, 1, 0, 0, "clr.b4");
        step(2, 1, 1, 0, 4'h0, 0, 0, 1, 0, "clr.b5");
        step(2, 1, 0, 0, 4'h0, 0, 0, 2, 0, "clr.b6");
        step(2, 1, 1, 0, 4'h0, 0, 0, 3, 0, "clr.b7");
        step(2, 1, 0, 0, 4'h0, 0, 1, 0, 1, "clr.b8");

        // Mid-clock asynchronous reset while in state 3 with pattern 1011 loaded.
        step(0, 1, 1, 0, 4'h0, 0, 0, 1, 3, "ar.b1");
        step(0, 1, 0, 0, 4'h0, 0, 0, 2, 3, "ar.b2");
        step(0, 1, 1, 0, 4'h0, 0, 0, 3, 3, "ar.b3");
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("ar.state",  get_state(0),  0);
        chk("ar.cnt",    get_cnt(0),    0);
        chk("ar.dout_q", get_dout_q(0), 0);
        chk("ar.dout",   get_dout(0),   0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        // Pattern is back to 1010: exactly one match.
        step(0, 1, 1, 0, 4'h0, 0, 0, 1, 0, "post.b1");
        step(0, 1, 0, 0, 4'h0, 0, 0, 2, 0, "post.b2");
        step(0, 1, 1, 0, 4'h0, 0, 0, 3, 0, "post.b3");
        step(0, 1, 0, 0, 4'h0, 0, 1, 0, 1, "post.b4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
